aq_bju_tar_chk: RTL and testbench

Branch/jump target checker and IFU redirect stage. It sits directly downstream of the BJU address generator. It captures the 64-bit computed target together with the EX1 branch outcome and prediction, compares actual against predicted next-PC, and registers the result into EX2. On a mismatch it raises a held valid/ready redirect request to the IFU and stalls EX1 until the IFU accepts it.

---
 rtl/aq_bju_tar_chk.sv | 126 ++++++++++++
 tb/tb_aq_bju_tar_chk.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_bju_tar_chk.sv
// Branch/jump target checker: resolves actual next-PC in EX1, flags mispredicts into EX2,
// and holds a valid/ready redirect request to the IFU while stalling EX1.
module aq_bju_tar_chk #(
    parameter int PC_WIDTH = 40
) (
    input  logic                forever_cpuclk,
    input  logic                cpurst_b,
    input  logic [63:0]         ag_bju_pc,
    input  logic                bju_chk_ex1_vld,
    input  logic                bju_chk_ex1_is_jmp,
    input  logic                bju_chk_ex1_cond_taken,
    input  logic                bju_chk_ex1_pred_taken,
    input  logic [PC_WIDTH-1:0] bju_chk_ex1_pred_pc,
    input  logic [PC_WIDTH-1:0] bju_chk_ex1_cur_pc,
    input  logic                bju_chk_ex1_inst_16,
    input  logic                rtu_yy_xx_flush,
    input  logic                ifu_chk_redir_rdy,
    output logic                chk_ifu_redir_vld,
    output logic [PC_WIDTH-1:0] chk_ifu_redir_pc,
    output logic                chk_idu_ex1_stall,
    output logic                chk_rtu_ex2_vld,
    output logic                chk_rtu_ex2_mispred,
    output logic                chk_rtu_ex2_tar_expt,
    output logic                chk_hpcp_mispred
);

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] redir_pc_q, redir_pc_d;
    logic                ex2_vld_q, ex2_vld_d;
    logic                ex2_mispred_q, ex2_mispred_d;
    logic                ex2_tar_expt_q, ex2_tar_expt_d;

    logic                ex1_acc;
    logic                act_taken;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] tar_pc;
    logic [PC_WIDTH-1:0] act_pc;
    logic                ex1_mispred;
    logic                ex1_tar_expt;

    function automatic logic [PC_WIDTH-1:0] seq_pc_f(input logic [PC_WIDTH-1:0] pc,
                                                     input logic              inst_16);
        return pc + (inst_16 ? PC_WIDTH'(2) : PC_WIDTH'(4));
    endfunction

    // Upper target bits must be a pure sign extension of the top PC bit.
    function automatic logic tar_expt_f(input logic [63:0] tar);
        logic [63-PC_WIDTH+1:0] hi;
        hi = tar[63:PC_WIDTH-1];
        return ~(&hi | ~|hi);
    endfunction

    // EX1 resolution
    assign act_taken    = bju_chk_ex1_is_jmp | bju_chk_ex1_cond_taken;
    assign seq_pc       = seq_pc_f(bju_chk_ex1_cur_pc, bju_chk_ex1_inst_16);
    assign tar_pc       = ag_bju_pc[PC_WIDTH-1:0] & ~PC_WIDTH'(1);
    assign act_pc       = act_taken ? tar_pc : seq_pc;
    assign ex1_mispred  = (act_taken != bju_chk_ex1_pred_taken) | (act_pc != bju_chk_ex1_pred_pc);
    assign ex1_tar_expt = act_taken & tar_expt_f(ag_bju_pc);

    assign chk_idu_ex1_stall = (state_q == REDIR) & ~ifu_chk_redir_rdy;

    // The handshake cycle drops the stall, but the held instruction is only taken once back in IDLE.
    assign ex1_acc = bju_chk_ex1_vld & ~chk_idu_ex1_stall & ~rtu_yy_xx_flush & (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        case (state_q)
            IDLE: begin
                if (ex1_acc && ex1_mispred) begin
                    state_d    = REDIR;
                    redir_pc_d = act_pc;
                end
            end
            REDIR: begin
                if (rtu_yy_xx_flush || ifu_chk_redir_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ex2_vld_d      = ex1_acc;
        ex2_mispred_d  = ex2_mispred_q;
        ex2_tar_expt_d = ex2_tar_expt_q;
        if (ex1_acc) begin
            ex2_mispred_d  = ex1_mispred;
            ex2_tar_expt_d = ex1_tar_expt;
        end
    end

    // EX1 -> EX2 boundary (control)
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= IDLE;
            redir_pc_q <= '0;
            ex2_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            ex2_vld_q  <= ex2_vld_d;
        end
    end

    // EX1 -> EX2 boundary (data, qualified by ex2_vld_q)
    always_ff @(posedge forever_cpuclk) begin
        ex2_mispred_q  <= ex2_mispred_d;
        ex2_tar_expt_q <= ex2_tar_expt_d;
    end

    assign chk_ifu_redir_vld    = (state_q == REDIR);
    assign chk_ifu_redir_pc     = redir_pc_q;
    assign chk_rtu_ex2_vld      = ex2_vld_q;
    assign chk_rtu_ex2_mispred  = ex2_vld_q & ex2_mispred_q;
    assign chk_rtu_ex2_tar_expt = ex2_vld_q & ex2_tar_expt_q;
    assign chk_hpcp_mispred     = chk_rtu_ex2_mispred;

endmodule

// File: tb/tb_aq_bju_tar_chk.sv
// Directed bench for aq_bju_tar_chk: reference model compared every cycle plus literal pins.
module tb_aq_bju_tar_chk;

    logic        clk;
    logic        rst_n;
    logic [63:0] ag;
    logic        vld, jmp, cond, pt, i16, flush, rdy;
    logic [39:0] ppc, cur;
    logic        redir_vld, stall, ex2_vld, ex2_mp, ex2_te, hpcp;
    logic [39:0] redir_pc;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 0;

    aq_bju_tar_chk #(.PC_WIDTH(40)) dut (
        .forever_cpuclk        (clk),
        .cpurst_b              (rst_n),
        .ag_bju_pc             (ag),
        .bju_chk_ex1_vld       (vld),
        .bju_chk_ex1_is_jmp    (jmp),
        .bju_chk_ex1_cond_taken(cond),
        .bju_chk_ex1_pred_taken(pt),
        .bju_chk_ex1_pred_pc   (ppc),
        .bju_chk_ex1_cur_pc    (cur),
        .bju_chk_ex1_inst_16   (i16),
        .rtu_yy_xx_flush       (flush),
        .ifu_chk_redir_rdy     (rdy),
        .chk_ifu_redir_vld     (redir_vld),
        .chk_ifu_redir_pc      (redir_pc),
        .chk_idu_ex1_stall     (stall),
        .chk_rtu_ex2_vld       (ex2_vld),
        .chk_rtu_ex2_mispred   (ex2_mp),
        .chk_rtu_ex2_tar_expt  (ex2_te),
        .chk_hpcp_mispred      (hpcp)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: next-PC evaluated with plain arithmetic on 64-bit integers.
    function automatic void eval(input logic j, input logic c, input logic p,
                                 input logic [39:0] pp, input logic [39:0] cp,
                                 input logic h, input logic [63:0] a,
                                 output bit mp, output logic [39:0] apc, output bit te);
        longint unsigned seq, tar;
        longint          s;
        bit              taken;
        taken = j || c;
        seq   = (64'(cp) + (h ? 64'd2 : 64'd4)) % (64'd1 << 40);
        tar   = ((a % (64'd1 << 40)) / 2) * 2;
        apc   = taken ? tar[39:0] : seq[39:0];
        mp    = (taken != p) || (apc != pp);
        s     = $signed(a) >>> 39;
        te    = taken && !(s == 0 || s == -1);
    endfunction

    bit          e_mp, e_te, e_acc;
    logic [39:0] e_apc;
    bit          m_redir, m_ex2v, m_ex2m, m_ex2e;
    logic [39:0] m_rpc;

    always_comb begin
        e_mp  = 0;
        e_te  = 0;
        e_apc = '0;
        eval(jmp, cond, pt, ppc, cur, i16, ag, e_mp, e_apc, e_te);
        e_acc = vld && !m_redir && !flush;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_redir <= 0; m_rpc <= '0; m_ex2v <= 0; m_ex2m <= 0; m_ex2e <= 0;
        end else begin
            m_ex2v <= e_acc;
            if (e_acc) begin
                m_ex2m <= e_mp;
                m_ex2e <= e_te;
            end
            if (flush) m_redir <= 0;
            else if (m_redir) begin
                if (rdy) m_redir <= 0;
            end else if (e_acc && e_mp) begin
                m_redir <= 1;
                m_rpc   <= e_apc;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_redir_vld", 64'(redir_vld), 64'(m_redir));
            chk("m_redir_pc",  64'(redir_pc),  64'(m_rpc));
            chk("m_stall",     64'(stall),     64'(m_redir && !rdy));
            chk("m_ex2_vld",   64'(ex2_vld),   64'(m_ex2v));
            chk("m_ex2_mp",    64'(ex2_mp),    64'(m_ex2v && m_ex2m));
            chk("m_ex2_te",    64'(ex2_te),    64'(m_ex2v && m_ex2e));
            chk("m_hpcp",      64'(hpcp),      64'(m_ex2v && m_ex2m));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        vld = 0; jmp = 0; cond = 0; pt = 0; ppc = '0; cur = '0; i16 = 0; ag = '0;
    endtask

    task automatic set_br(input logic j, input logic c, input logic p, input logic [39:0] pp,
                          input logic [39:0] cp, input logic h, input logic [63:0] a);
        vld = 1; jmp = j; cond = c; pt = p; ppc = pp; cur = cp; i16 = h; ag = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; flush = 0; rdy = 0;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_redir_vld", 64'(redir_vld), 64'd0);
        chk("rst_redir_pc",  64'(redir_pc),  64'd0);
        chk("rst_ex2_vld",   64'(ex2_vld),   64'd0);
        chk("rst_hpcp",      64'(hpcp),      64'd0);
        #1 rst_n = 1;
        cmp_en = 1;
        step();

        // Correct taken branch
        set_br(0, 1, 1, 40'h1040, 40'h1000, 0, 64'h1040);
        step();
        chk("t1_ex2_vld",   64'(ex2_vld),   64'd1);
        chk("t1_mispred",   64'(ex2_mp),    64'd0);
        chk("t1_redir_vld", 64'(redir_vld), 64'd0);
        idle_in();
        step();

        // Not-taken mispredict, IFU ready immediately
        rdy = 1;
        set_br(0, 0, 1, 40'h2100, 40'h2000, 0, 64'h0);
        step();
        chk("t2_redir_vld", 64'(redir_vld), 64'd1);
        chk("t2_redir_pc",  64'(redir_pc),  64'h2004);
        chk("t2_mispred",   64'(ex2_mp),    64'd1);
        chk("t2_hpcp",      64'(hpcp),      64'd1);
        chk("t2_stall",     64'(stall),     64'd0);
        idle_in();
        step();
        chk("t2_redir_off", 64'(redir_vld), 64'd0);
        chk("t2_hpcp_off",  64'(hpcp),      64'd0);
        rdy = 0;
        step();

        // Stalled jalr redirect, following instruction held then accepted
        set_br(1, 0, 0, 40'h0, 40'h2F00, 0, 64'h3001);
        step();
        chk("t3_redir_vld", 64'(redir_vld), 64'd1);
        chk("t3_redir_pc",  64'(redir_pc),  64'h3000);
        chk("t3_mispred",   64'(ex2_mp),    64'd1);
        chk("t3_stall",     64'(stall),     64'd1);
        set_br(0, 0, 0, 40'h3004, 40'h3000, 0, 64'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t3_stall_hold", 64'(stall),     64'd1);
            chk("t3_pc_hold",    64'(redir_pc),  64'h3000);
            chk("t3_ex2_quiet",  64'(ex2_vld),   64'd0);
        end
        step();
        rdy = 1;
        #1;
        chk("t3_stall_drop", 64'(stall),     64'd0);
        chk("t3_hs_vld",     64'(redir_vld), 64'd1);
        step();
        chk("t3_redir_off",  64'(redir_vld), 64'd0);
        chk("t3_no_acc_hs",  64'(ex2_vld),   64'd0);
        step();
        chk("t3_acc_next",   64'(ex2_vld),   64'd1);
        chk("t3_acc_ok",     64'(ex2_mp),    64'd0);
        idle_in();
        rdy = 0;
        step();

        // Flush during REDIR together with rdy, then flush in IDLE
        set_br(0, 1, 1, 40'h4100, 40'h4000, 0, 64'h4080);
        step();
        chk("t4_redir_pc",  64'(redir_pc), 64'h4080);
        set_br(0, 0, 0, 40'h5004, 40'h5000, 0, 64'h0);
        flush = 1;
        rdy = 1;
        step();
        chk("t4_flush_vld", 64'(redir_vld), 64'd0);
        chk("t4_flush_ex2", 64'(ex2_vld),   64'd0);
        flush = 0;
        step();
        chk("t4_resume",    64'(ex2_vld),   64'd1);
        rdy = 0;
        set_br(0, 0, 1, 40'h6100, 40'h6000, 0, 64'h0);
        flush = 1;
        step();
        chk("t4_idle_flush_ex2",   64'(ex2_vld),   64'd0);
        chk("t4_idle_flush_redir", 64'(redir_vld), 64'd0);
        flush = 0;
        idle_in();
        step();

        // Back-to-back: PC wrap, target exception, sign-extended high target, bit-0 clear
        set_br(0, 0, 0, 40'h0, 40'hFF_FFFF_FFFE, 1, 64'h0);
        step();
        chk("t5_wrap_vld", 64'(ex2_vld), 64'd1);
        chk("t5_wrap_mp",  64'(ex2_mp),  64'd0);
        set_br(1, 0, 1, 40'h0, 40'h10, 0, 64'h0000_0100_0000_0000);
        step();
        chk("t5_expt",     64'(ex2_te),    64'd1);
        chk("t5_expt_mp",  64'(ex2_mp),    64'd0);
        chk("t5_expt_rd",  64'(redir_vld), 64'd0);
        set_br(1, 0, 1, 40'h80_0000_1000, 40'h20, 0, 64'hFFFF_FF80_0000_1000);
        step();
        chk("t5_sext_te",  64'(ex2_te), 64'd0);
        chk("t5_sext_mp",  64'(ex2_mp), 64'd0);
        set_br(1, 0, 1, 40'h5002, 40'h30, 0, 64'h5003);
        step();
        chk("t5_bit0_mp",  64'(ex2_mp), 64'd0);
        chk("t5_bit0_vld", 64'(ex2_vld), 64'd1);
        idle_in();
        step();

        // Async reset while a redirect is pending
        set_br(0, 1, 0, 40'h0, 40'h6000, 0, 64'h6200);
        step();
        chk("t6_redir_vld", 64'(redir_vld), 64'd1);
        chk("t6_redir_pc",  64'(redir_pc),  64'h6200);
        idle_in();
        #2 rst_n = 0;
        #1;
        chk("t6_rst_vld",   64'(redir_vld), 64'd0);
        chk("t6_rst_pc",    64'(redir_pc),  64'd0);
        chk("t6_rst_stall", 64'(stall),     64'd0);
        chk("t6_rst_ex2",   64'(ex2_vld),   64'd0);
        chk("t6_rst_hpcp",  64'(hpcp),      64'd0);
        @(posedge clk);
        #3 rst_n = 1;
        step();
        step();
        chk("t6_post_idle", 64'(redir_vld), 64'd0);
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
